// File: rtl/led_pkg.sv
// Shared types for the multi-channel LED controller: channel modes,
// reset defaults and the per-channel configuration word.
package led_pkg;

   typedef enum logic [1:0] {
      LED_OFF     = 2'd0,
      LED_ON      = 2'd1,
      LED_BLINK   = 2'd2,
      LED_BREATHE = 2'd3
   } led_mode_t;

   localparam logic [15:0] RST_PERIOD = 16'd1000;

   // Duty is carried at the widest supported resolution and zero-extended.
   localparam int DUTY_W = 16;

   typedef struct packed {
      led_mode_t         mode;
      logic [15:0]       period;
      logic [DUTY_W-1:0] duty;
   } led_cfg_t;

endpackage

// File: rtl/led_cfg_if.sv
// Configuration write port of led_ctrl: a single-cycle strobe plus the
// target channel and the mode, period and duty fields.
interface led_cfg_if #(
   parameter int CH_W     = 2,
   parameter int PWM_BITS = 8
) ();
   logic                cfg_we;
   logic [CH_W-1:0]     cfg_ch;
   logic [1:0]          cfg_mode;
   logic [15:0]         cfg_period;
   logic [PWM_BITS-1:0] cfg_duty;

   modport master (output cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty);
   modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty);
endinterface

// File: rtl/led_chan.sv
// One LED channel: holds its configuration, blink ms counter and breathe
// ramp, and produces the unregistered drive bit from the shared PWM carrier.
module led_chan
   import led_pkg::*;
#(
   parameter int        PWM_BITS = 8,
   parameter led_mode_t RST_MODE = LED_OFF
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                ms_tick,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                we,
   input  led_cfg_t            cfg_in,
   output logic                raw
);

   localparam logic [DUTY_W-1:0] FULL = DUTY_W'((32'd1 << PWM_BITS) - 32'd1);

   led_mode_t           mode_q;
   logic [15:0]         period_q;
   logic [DUTY_W-1:0]   duty_q;
   logic [15:0]         ms_cnt;
   logic [PWM_BITS-1:0] level;
   logic                dir_up;
   logic [15:0]         eff_period;

   assign eff_period = (period_q == 16'd0) ? 16'd1 : period_q;

   function automatic logic pwm_on(input logic [DUTY_W-1:0] x,
                                   input logic [PWM_BITS-1:0] cnt);
      return (x == FULL) || (DUTY_W'(cnt) < x);
   endfunction

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mode_q   <= RST_MODE;
         period_q <= RST_PERIOD;
         duty_q   <= FULL;
         ms_cnt   <= 16'd0;
         level    <= '0;
         dir_up   <= 1'b1;
      end else if (we) begin
         // A write also restarts the blink phase and breathe ramp, even on a tick.
         mode_q   <= cfg_in.mode;
         period_q <= cfg_in.period;
         duty_q   <= cfg_in.duty;
         ms_cnt   <= 16'd0;
         level    <= '0;
         dir_up   <= 1'b1;
      end else if (ms_tick) begin
         if (mode_q == LED_BLINK)
            ms_cnt <= (ms_cnt >= eff_period - 16'd1) ? 16'd0 : ms_cnt + 16'd1;
         if (mode_q == LED_BREATHE) begin
            if (duty_q == '0) begin
               level  <= '0;
               dir_up <= 1'b1;
            end else if (dir_up) begin
               level <= level + PWM_BITS'(1);
               if (DUTY_W'(level) + DUTY_W'(1) >= duty_q) dir_up <= 1'b0;
            end else begin
               level <= level - PWM_BITS'(1);
               if (level == PWM_BITS'(1)) dir_up <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      raw = 1'b0;
      unique case (mode_q)
         LED_OFF:     raw = 1'b0;
         LED_ON:      raw = pwm_on(duty_q, pwm_cnt);
         LED_BLINK:   raw = (ms_cnt < (eff_period >> 1)) && pwm_on(duty_q, pwm_cnt);
         LED_BREATHE: raw = pwm_on(DUTY_W'(level), pwm_cnt);
      endcase
   end

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED controller top: 1 ms prescaler, shared PWM carrier,
// channel address decode and the registered LED outputs.
module led_ctrl
   import led_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int NUM_LED    = 4,
   parameter int PWM_BITS   = 8,
   parameter int ACTIVE_LOW = 0,
   parameter int RST_BLINK  = 1
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   led_cfg_if.slave           cfg,
   output logic [NUM_LED-1:0] led,
   output logic               ms_tick
);

   localparam int DIV   = CLK_FREQ / 1000;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CH_W  = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
   localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(DIV - 1);
   localparam logic [NUM_LED-1:0] POL     = (ACTIVE_LOW != 0) ? '1 : '0;

   logic [PRE_W-1:0]    pre;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [NUM_LED-1:0]  raw_v;
   logic [NUM_LED-1:0]  we_v;
   led_cfg_t            cfg_word;

   assign ms_tick = (pre == PRE_MAX);

   assign cfg_word.mode   = led_mode_t'(cfg.cfg_mode);
   assign cfg_word.period = cfg.cfg_period;
   assign cfg_word.duty   = DUTY_W'(cfg.cfg_duty);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pre     <= '0;
         pwm_cnt <= '0;
         led     <= POL;
      end else begin
         pre     <= ms_tick ? '0 : pre + PRE_W'(1);
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         led     <= raw_v ^ POL;
      end
   end

   // Channel numbers at or above NUM_LED match no decode and are dropped.
   for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
      assign we_v[i] = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

      led_chan #(
         .PWM_BITS (PWM_BITS),
         .RST_MODE ((i == 0 && RST_BLINK != 0) ? LED_BLINK : LED_OFF)
      ) u_chan (
         .sys_clk   (sys_clk),
         .sys_rst_n (sys_rst_n),
         .ms_tick   (ms_tick),
         .pwm_cnt   (pwm_cnt),
         .we        (we_v[i]),
         .cfg_in    (cfg_word),
         .raw       (raw_v[i])
      );
   end

endmodule

// File: tb/tb_led_ctrl.sv
// Scoreboard bench for led_ctrl: an arithmetic model predicts every cycle's
// led/ms_tick from time since the last write; a monitor compares on negedge.
module tb_led_ctrl;
   import led_pkg::*;

   localparam int MS   = 8;
   localparam int PWMP = 16;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 sys_clk = ~sys_clk;

   led_cfg_if #(.CH_W(2), .PWM_BITS(4)) cfg_a ();
   led_cfg_if #(.CH_W(2), .PWM_BITS(4)) cfg_b ();

   logic [3:0] led_a;
   logic       ms_tick_a;
   logic [2:0] led_b;
   logic       ms_tick_b;

   led_ctrl #(.CLK_FREQ(8000), .NUM_LED(4), .PWM_BITS(4), .ACTIVE_LOW(0), .RST_BLINK(1)) dut (
      .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .cfg (cfg_a), .led (led_a), .ms_tick (ms_tick_a));

   led_ctrl #(.CLK_FREQ(8000), .NUM_LED(3), .PWM_BITS(4), .ACTIVE_LOW(1), .RST_BLINK(0)) dut_b (
      .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .cfg (cfg_b), .led (led_b), .ms_tick (ms_tick_b));

   typedef struct { int mode; int period; int duty; int w; } mcfg_t;
   typedef struct { int ch; mcfg_t c; } wr_t;
   typedef struct { logic [3:0] led; logic tick; int cyc; } exp_t;

   mcfg_t cur [4];
   wr_t   wq [$];
   exp_t  sb [$];
   int    cyc;
   int    n_tests = 0;
   int    n_fail  = 0;

   function automatic bit pwm_on(int x, int j);
      return (x == PWMP - 1) || ((j % PWMP) < x);
   endfunction

   // Expected raw drive of one channel during cycle j.
   function automatic bit model_raw(mcfg_t c, int j);
      int n, p, ph, lvl;
      n = j / MS - c.w / MS;
      case (c.mode)
         1: return pwm_on(c.duty, j);
         2: begin
            p = (c.period == 0) ? 1 : c.period;
            return ((n % p) < (p / 2)) && pwm_on(c.duty, j);
         end
         3: begin
            if (c.duty == 0) return 1'b0;
            ph  = n % (2 * c.duty);
            lvl = (ph <= c.duty) ? ph : 2 * c.duty - ph;
            return pwm_on(lvl, j);
         end
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] model_led(int j);
      logic [3:0] r;
      while (wq.size() > 0 && wq[0].c.w <= j) begin
         cur[wq[0].ch] = wq[0].c;
         void'(wq.pop_front());
      end
      for (int i = 0; i < 4; i++) r[i] = model_raw(cur[i], j);
      return r;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         cur[i].mode   = (i == 0) ? 2 : 0;
         cur[i].period = 1000;
         cur[i].duty   = 15;
         cur[i].w      = 0;
      end
      wq.delete();
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge sys_clk);
      cyc++;
      #1;
      cfg_a.cfg_we = 1'b0;
      cfg_b.cfg_we = 1'b0;
      e.led  = model_led(cyc - 1);
      e.tick = ((cyc % MS) == MS - 1);
      e.cyc  = cyc;
      sb.push_back(e);
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input int ch, input int mode, input int per, input int duty);
      wr_t x;
      cfg_a.cfg_we     = 1'b1;
      cfg_a.cfg_ch     = 2'(ch);
      cfg_a.cfg_mode   = 2'(mode);
      cfg_a.cfg_period = 16'(per);
      cfg_a.cfg_duty   = 4'(duty);
      x.ch = ch;
      x.c.mode = mode; x.c.period = per; x.c.duty = duty; x.c.w = cyc + 1;
      wq.push_back(x);
      tick();
   endtask

   task automatic wr_b(input int ch, input int mode, input int duty);
      cfg_b.cfg_we     = 1'b1;
      cfg_b.cfg_ch     = 2'(ch);
      cfg_b.cfg_mode   = 2'(mode);
      cfg_b.cfg_period = 16'd1000;
      cfg_b.cfg_duty   = 4'(duty);
      tick();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge sys_clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (led_a !== e.led || ms_tick_a !== e.tick) begin
               n_fail++;
               $display("FAIL scoreboard cycle %0d: led/ms_tick got %b/%b expected %b/%b",
                        e.cyc, led_a, ms_tick_a, e.led, e.tick);
            end
         end
      end
   end

   initial begin : stim
      int ch, mode, per, duty;
      cfg_a.cfg_we = 1'b0; cfg_a.cfg_ch = '0; cfg_a.cfg_mode = '0; cfg_a.cfg_period = '0; cfg_a.cfg_duty = '0;
      cfg_b.cfg_we = 1'b0; cfg_b.cfg_ch = '0; cfg_b.cfg_mode = '0; cfg_b.cfg_period = '0; cfg_b.cfg_duty = '0;
      cyc = 0;
      model_reset();

      #23;
      chk("reset_led_a", 32'(led_a), 32'h0);
      chk("reset_tick_a", 32'(ms_tick_a), 32'h0);
      chk("reset_led_b_active_low", 32'(led_b), 32'h7);
      chk("reset_tick_b", 32'(ms_tick_b), 32'h0);

      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      cyc = 0;
      model_reset();

      run(8100);                              // default 1 s blink on ch0
      wr(1, 1, 0, 4);   run(64);
      wr(1, 1, 0, 15);  run(32);
      wr(2, 2, 5, 15);  run(130);
      wr(2, 2, 0, 15);  run(40);
      wr(3, 3, 0, 3);   run(120);
      wr(3, 3, 0, 0);   run(40);
      while ((cyc % MS) != MS - 1) tick();   // write lands on the ms_tick edge
      wr(2, 2, 4, 15);  run(80);

      // Second instance: inverted outputs, out-of-range channel ignored.
      run(3);
      chk("b_idle_inverted", 32'(led_b), 32'h7);
      wr_b(3, 1, 15); run(4);
      chk("b_bad_channel_ignored", 32'(led_b), 32'h7);
      wr_b(1, 1, 15); run(4);
      chk("b_ch1_on_inverted", 32'(led_b), 32'h5);

      repeat (60) begin
         ch   = int'($urandom_range(0, 3));
         mode = int'($urandom_range(0, 3));
         per  = int'($urandom_range(0, 9));
         duty = int'($urandom_range(0, 15));
         wr(ch, mode, per, duty);
         run(int'($urandom_range(0, 150)));
      end

      // Asynchronous reset in the middle of ch0's ON phase.
      wr(0, 2, 1000, 15);
      wr(1, 0, 0, 0); wr(2, 0, 0, 0); wr(3, 0, 0, 0);
      run(400);
      @(negedge sys_clk);
      chk("pre_reset_led0_on", 32'(led_a[0]), 32'h1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("async_reset_led_a", 32'(led_a), 32'h0);
      chk("async_reset_tick_a", 32'(ms_tick_a), 32'h0);
      chk("async_reset_led_b", 32'(led_b), 32'h7);
      @(posedge sys_clk); #1;
      chk("held_reset_led_a", 32'(led_a), 32'h0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      cyc = 0;
      model_reset();
      run(4100);

      repeat (4) @(negedge sys_clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/led_ctrl.md
# led_ctrl

Multi-channel LED controller: the parametrised successor to the board's single fixed 1 s blinker. It drives NUM_LED outputs, each independently set to OFF, ON, BLINK or BREATHE with its own period and brightness, from one shared 1 ms timebase and one shared PWM carrier. It sits at the top level next to the board LEDs and is configured by any internal master through a single-cycle write strobe.

## Interface
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz; must be a multiple of 1000.
- NUM_LED, 4: number of LED channels, 1..16.
- PWM_BITS, 8: brightness resolution; the carrier period is 2^PWM_BITS clocks.
- ACTIVE_LOW, 0: if 1, every `led` bit is inverted at the output register.
- RST_BLINK, 1: if 1, channel 0 leaves reset in BLINK with period 1000 and full duty; otherwise it leaves reset in OFF.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  single-cycle configuration write strobe.
- cfg_ch  in  $clog2(NUM_LED) (minimum 1)  target channel.
- cfg_mode  in  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
- cfg_period  in  16  blink period in ms; 0 is treated as 1.
- cfg_duty  in  PWM_BITS  brightness; all-ones means constant on.
- led  out  NUM_LED  registered LED drive, one bit per channel.
- ms_tick  out  1  one-cycle pulse every 1 ms, exported for other blocks.

## Operation
- **Prescaler:** counts 0..CLK_FREQ/1000−1, then wraps. `ms_tick` is high during the terminal-count cycle.
- **PWM counter:** `pwm_cnt` is PWM_BITS wide and free-running; it increments every clock and wraps.
- **PWM compare:** `pwm_on(x)` = (x == all-ones) OR (pwm_cnt < x).
- **Per-channel state:** mode, period (16 b), duty, ms_cnt (16 b), level (PWM_BITS), dir (up/down).
- **OFF:** raw output is 0.
- **ON:** raw output is `pwm_on(duty)`.
- **BLINK:**
  - On each `ms_tick`, ms_cnt goes to 0 if ms_cnt ≥ period−1, else ms_cnt+1.
  - Raw output is (ms_cnt < max(period,1)>>1) AND `pwm_on(duty)`.
  - Period 1 therefore gives constant off.
- **BREATHE:**
  - On each `ms_tick`, level moves one step in direction dir.
  - While rising, when level reaches duty, dir flips to down on that tick.
  - While falling, when level reaches 0, dir flips to up.
  - Raw output is `pwm_on(level)`; the full cycle is 2·duty ms.
  - If duty = 0, level stays 0 and the output stays off.
- **Configuration write:**
  - On cfg_we with cfg_ch < NUM_LED, that channel loads mode, period and duty, and clears ms_cnt = 0, level = 0, dir = up.
  - Other channels are unaffected.
  - A write with cfg_ch ≥ NUM_LED is ignored.
- **Output register:** `led[i]` is the raw output XOR ACTIVE_LOW.
- **Reset values:**
  - Prescaler, pwm_cnt, ms_cnt and level are 0; dir is up.
  - Every mode is OFF, except channel 0 when RST_BLINK = 1.
  - Every period is 1000 and every duty is all-ones.
  - `led` is all ACTIVE_LOW, i.e. every LED is dark.
  - `ms_tick` is 0.

## Timing
- A cfg_we sampled at edge N updates the channel registers at edge N. The `led` output reflects the new mode from edge N+1.
- If cfg_we coincides with `ms_tick` for the same channel, the write wins: ms_cnt and level are cleared, not advanced.
- The output is registered, so there is one clock of latency from pwm_cnt/ms_cnt to `led`. No combinational path runs from any input to `led`.
- Assertion of `sys_rst_n` mid-operation forces all outputs to their reset values immediately, without waiting for a clock. Release is synchronous in effect: the counters start on the first edge after deassertion.
- Changing only duty in BREATHE by a new write restarts the ramp from 0.

## Structure
- **led_pkg:** holds the mode enum (LED_OFF, LED_ON, LED_BLINK, LED_BREATHE), the RST_PERIOD constant (1000), and the per-channel config struct (mode, period, duty).
- **led_chan:** one sub-module per channel, instantiated NUM_LED times in a generate loop.
  - Owns ms_cnt, level, dir and the raw output.
  - Takes the shared ms_tick and pwm_cnt, its write-enable, and the config fields.
- **Top level:** holds the prescaler, pwm_cnt, address decode and the output register.

## Test plan
All scenarios use CLK_FREQ = 8000 (8 clocks per ms) and PWM_BITS = 4.

1. **Reset default:** release reset, with RST_BLINK = 1 and ACTIVE_LOW = 0. Required: led[0] = 1 for 500 ms and 0 for 500 ms, repeating; led[3:1] = 0 throughout; ms_tick period is 8 clocks.
2. **ON at partial duty:** write ch1 ON with duty = 4. Required: led[1] is high for exactly 4 of every 16 clocks. Then write duty = 15: led[1] is constantly 1.
3. **BLINK, odd and zero period:** write ch2 BLINK with period = 5. Required: led[2] is high for 2 ms and low for 3 ms. Then write period = 0: led[2] is constantly 0.
4. **BREATHE:** write ch3 BREATHE with duty = 3. Required: level sequence 0,1,2,3,2,1,0,1… with one step per ms. In the ms where level = 2, led[3] is high 2 of every 16 clocks. Then write duty = 0: the output stays 0.
5. **Boundary events:**
   - Write ch2 on the same cycle as ms_tick: ms_cnt = 0 afterwards.
   - Write with cfg_ch = NUM_LED: no register changes.
   - ACTIVE_LOW = 1: all led bits are inverted and read 1 during reset.
6. **Reset mid-blink:** drop sys_rst_n during the ON phase of ch0. Required: led goes to 0 with no clock edge; after release, channel 0 restarts the full 500 ms ON phase.
